// File: rtl/wishbone_spi_controller.sv
// Wishbone-classic responder driving a byte-wide SPI master (MSB first, programmable SCK divider).
// Optional `SPI_MODE_EN adds CPOL/CPHA control in CTRL[2:1]; without it the port is fixed to mode 0.
module wishbone_spi_controller #(
    parameter logic [7:0] DIV_RESET = 8'd3
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [3:0]  wb_sel_i,
    input  logic [1:0]  wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    input  logic        spi_miso_i,
    output logic        spi_mosi_o,
    output logic        spi_sck_o,
    output logic        spi_cs_o
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } state_e;

    localparam logic [1:0] ADR_DATA   = 2'd0;
    localparam logic [1:0] ADR_STATUS = 2'd1;
    localparam logic [1:0] ADR_CTRL   = 2'd2;

    state_e      state_q, state_d;
    logic        ack_q, ack_d;
    logic [31:0] dat_q, dat_d;
    logic        sck_q, sck_d;
    logic        mosi_q, mosi_d;
    logic        cs_assert_q, cs_assert_d;
    logic [7:0]  div_q, div_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [3:0]  half_q, half_d;
    logic [7:0]  tx_shift_q, tx_shift_d;
    logic [7:0]  rx_shift_q, rx_shift_d;
    logic [7:0]  rx_byte_q, rx_byte_d;
    logic        rx_valid_q, rx_valid_d;
    logic        overrun_q, overrun_d;

    logic        accept_s;
    logic        busy_s;
    logic        start_s;
    logic        cpol_s;
    logic        cpha_s;
    logic        unused_s;

`ifdef SPI_MODE_EN
    logic        cpol_q, cpol_d;
    logic        cpha_q, cpha_d;
    assign cpol_s = cpol_q;
    assign cpha_s = cpha_q;
`else
    assign cpol_s = 1'b0;
    assign cpha_s = 1'b0;
`endif

    assign accept_s = wb_cyc_i & wb_stb_i & ~ack_q;
    assign busy_s   = (state_q == ST_XFER);
    assign unused_s = ^{wb_dat_i[31:16], wb_sel_i[3:2]};

    // Next-state logic: bus decode, register updates and the shift engine.
    always_comb begin
        state_d     = state_q;
        ack_d       = 1'b0;
        dat_d       = 32'd0;
        sck_d       = sck_q;
        mosi_d      = mosi_q;
        cs_assert_d = cs_assert_q;
        div_d       = div_q;
        cnt_d       = cnt_q;
        half_d      = half_q;
        tx_shift_d  = tx_shift_q;
        rx_shift_d  = rx_shift_q;
        rx_byte_d   = rx_byte_q;
        rx_valid_d  = rx_valid_q;
        overrun_d   = overrun_q;
        start_s     = 1'b0;
`ifdef SPI_MODE_EN
        cpol_d      = cpol_q;
        cpha_d      = cpha_q;
`endif

        if (accept_s) begin
            ack_d = 1'b1;
            if (wb_we_i) begin
                case (wb_adr_i)
                    ADR_DATA: begin
                        start_s = wb_sel_i[0] & ~busy_s;
                    end
                    ADR_CTRL: begin
                        if (wb_sel_i[0]) begin
                            cs_assert_d = wb_dat_i[0];
`ifdef SPI_MODE_EN
                            if (!busy_s) begin
                                cpol_d = wb_dat_i[1];
                                cpha_d = wb_dat_i[2];
                            end else begin
                                cpol_d = cpol_q;
                                cpha_d = cpha_q;
                            end
`endif
                        end else begin
                            cs_assert_d = cs_assert_q;
                        end
                        if (wb_sel_i[1] && !busy_s) begin
                            div_d = wb_dat_i[15:8];
                        end else begin
                            div_d = div_q;
                        end
                    end
                    default: begin
                        start_s = 1'b0;
                    end
                endcase
            end else begin
                case (wb_adr_i)
                    ADR_DATA: begin
                        dat_d      = {24'd0, rx_byte_q};
                        rx_valid_d = 1'b0;
                        overrun_d  = 1'b0;
                    end
                    ADR_STATUS: dat_d = {29'd0, overrun_q, rx_valid_q, busy_s};
                    ADR_CTRL:   dat_d = {16'd0, div_q, 5'd0, cpha_s, cpol_s, cs_assert_q};
                    default:    dat_d = 32'd0;
                endcase
            end
        end else begin
            ack_d = 1'b0;
        end

        // Completion below runs after the read-clear so a coincident set wins.
        case (state_q)
            ST_IDLE: begin
                sck_d = cpol_s;
                if (start_s) begin
                    state_d    = ST_XFER;
                    tx_shift_d = wb_dat_i[7:0];
                    mosi_d     = wb_dat_i[7];
                    half_d     = 4'd0;
                    cnt_d      = div_q;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_XFER: begin
                if (cnt_q == 8'd0) begin
                    sck_d  = ~sck_q;
                    cnt_d  = div_q;
                    half_d = half_q + 4'd1;
                    // Even half-periods end on the leading edge; CPHA swaps sample and shift edges.
                    if ((~half_q[0]) ^ cpha_s) begin
                        rx_shift_d = {rx_shift_q[6:0], spi_miso_i};
                    end else if (cpha_s) begin
                        mosi_d     = tx_shift_q[7];
                        tx_shift_d = {tx_shift_q[6:0], 1'b0};
                    end else begin
                        mosi_d     = tx_shift_q[6];
                        tx_shift_d = {tx_shift_q[6:0], 1'b0};
                    end
                    if (half_q == 4'd15) begin
                        state_d    = ST_IDLE;
                        rx_byte_d  = rx_shift_d;
                        rx_valid_d = 1'b1;
                        if (rx_valid_q) begin
                            overrun_d = 1'b1;
                        end else begin
                            overrun_d = overrun_d;
                        end
                    end else begin
                        state_d = ST_XFER;
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and register flops.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= ST_IDLE;
            ack_q       <= 1'b0;
            dat_q       <= 32'd0;
            sck_q       <= 1'b0;
            mosi_q      <= 1'b0;
            cs_assert_q <= 1'b0;
            div_q       <= DIV_RESET;
            cnt_q       <= 8'd0;
            half_q      <= 4'd0;
            tx_shift_q  <= 8'd0;
            rx_shift_q  <= 8'd0;
            rx_byte_q   <= 8'd0;
            rx_valid_q  <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef SPI_MODE_EN
            cpol_q      <= 1'b0;
            cpha_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            ack_q       <= ack_d;
            dat_q       <= dat_d;
            sck_q       <= sck_d;
            mosi_q      <= mosi_d;
            cs_assert_q <= cs_assert_d;
            div_q       <= div_d;
            cnt_q       <= cnt_d;
            half_q      <= half_d;
            tx_shift_q  <= tx_shift_d;
            rx_shift_q  <= rx_shift_d;
            rx_byte_q   <= rx_byte_d;
            rx_valid_q  <= rx_valid_d;
            overrun_q   <= overrun_d;
`ifdef SPI_MODE_EN
            cpol_q      <= cpol_d;
            cpha_q      <= cpha_d;
`endif
        end
    end

    assign wb_ack_o   = ack_q;
    assign wb_dat_o   = dat_q;
    assign spi_sck_o  = sck_q;
    assign spi_mosi_o = mosi_q;
    assign spi_cs_o   = ~cs_assert_q;

endmodule

// File: tb/tb_wishbone_spi_controller.sv
// Self-checking bench for wishbone_spi_controller: register vector table, hand-written
// transfer corner cases, then random bus traffic against a transaction-level model.
module tb_wishbone_spi_controller;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        wb_cyc_i = 1'b0;
    logic        wb_stb_i = 1'b0;
    logic        wb_we_i = 1'b0;
    logic [3:0]  wb_sel_i = 4'd0;
    logic [1:0]  wb_adr_i = 2'd0;
    logic [31:0] wb_dat_i = 32'd0;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic        spi_miso_i;
    logic        spi_mosi_o;
    logic        spi_sck_o;
    logic        spi_cs_o;

    wishbone_spi_controller dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
        .wb_sel_i(wb_sel_i), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i),
        .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
        .spi_miso_i(spi_miso_i), .spi_mosi_o(spi_mosi_o),
        .spi_sck_o(spi_sck_o), .spi_cs_o(spi_cs_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int failures = 0;

    // Number of the most recent rising clock edge.
    int edge_n = 0;
    always @(posedge clk_i) edge_n <= edge_n + 1;

    // SCK edge recorder: which clock edge produced each toggle, and mosi at that toggle.
    int   tog_cnt = 0;
    int   edge_at [8192];
    logic mosi_at [8192];
    logic sck_prev = 1'b0;
    always @(negedge clk_i) begin
        if (spi_sck_o !== sck_prev) begin
            edge_at[tog_cnt & 8191] <= edge_n;
            mosi_at[tog_cnt & 8191] <= spi_mosi_o;
            tog_cnt <= tog_cnt + 1;
        end
        sck_prev <= spi_sck_o;
    end

    // SPI slave: returns slave_val MSB first, changing bit after each falling SCK.
    int         tog_base = 0;
    logic [7:0] slave_val = 8'd0;
    logic       loopback = 1'b0;
    logic       slave_bit;
    int         bit_idx;
    logic [7:0] slave_sh;
    always_comb begin
        bit_idx   = (tog_cnt - tog_base) >>> 1;
        slave_sh  = 8'd0;
        slave_bit = 1'b0;
        if (bit_idx >= 0 && bit_idx < 8) begin
            slave_sh  = slave_val << bit_idx;
            slave_bit = slave_sh[7];
        end
    end
    assign spi_miso_i = loopback ? spi_mosi_o : slave_bit;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic at_neg();
        @(negedge clk_i);
        #1;
    endtask

    // One access, started just after a falling edge; strobe is held one extra edge to see ack drop.
    task automatic xact(input logic we, input logic [1:0] adr, input logic [3:0] sel,
                        input logic [31:0] wd, output logic [31:0] rd, output int acc);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
        wb_adr_i = adr; wb_sel_i = sel; wb_dat_i = wd;
        acc = edge_n + 1;
        @(posedge clk_i); #1;
        chk("ack", {31'd0, wb_ack_o}, 32'd1);
        rd = wb_dat_o;
        @(posedge clk_i); #1;
        chk("ack_single", {31'd0, wb_ack_o}, 32'd0);
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    endtask

    task automatic wr(input logic [1:0] adr, input logic [3:0] sel, input logic [31:0] wd, output int acc);
        logic [31:0] dummy;
        at_neg();
        xact(1'b1, adr, sel, wd, dummy, acc);
    endtask

    task automatic rd(input logic [1:0] adr, output logic [31:0] data);
        int acc;
        at_neg();
        xact(1'b0, adr, 4'hF, 32'd0, data, acc);
    endtask

    task automatic wait_edge(input int target);
        int g;
        g = 0;
        while (edge_n < target && g < 5000) begin
            at_neg();
            g++;
        end
        if (g >= 5000) begin
            checks++;
            failures++;
            $display("FAIL wait_timeout actual=%0d required=%0d", edge_n, target);
        end
    endtask

    // Check one finished transfer: toggle count, toggle timing and transmitted bits.
    task automatic chk_xfer(input string name, input int base, input int e0, input int div, input logic [7:0] tx);
        logic [7:0] sent;
        chk({name, "_toggles"}, tog_cnt - base, 32'd16);
        for (int k = 0; k < 16; k++) begin
            chk({name, "_edge"}, edge_at[(base + k) & 8191], e0 + (k + 1) * (div + 1));
        end
        for (int k = 0; k < 8; k++) begin
            sent[7 - k] = mosi_at[(base + 2 * k) & 8191];
        end
        chk({name, "_mosi"}, {24'd0, sent}, {24'd0, tx});
    endtask

    // Transaction-level reference: flags, registers and the completion edge of the pending byte.
    logic       m_busy, m_cs, m_rxv, m_ovr;
    logic [7:0] m_div, m_rx, m_pend;
    int         m_end;

    function automatic void m_reset();
        m_busy = 1'b0; m_cs = 1'b0; m_rxv = 1'b0; m_ovr = 1'b0;
        m_div = 8'd3; m_rx = 8'd0; m_pend = 8'd0; m_end = 0;
    endfunction

    function automatic void m_complete(input logic rxv_before);
        m_rx = m_pend;
        if (rxv_before) m_ovr = 1'b1;
        m_rxv = 1'b1;
        m_busy = 1'b0;
    endfunction

    function automatic void m_settle(input int e);
        if (m_busy && m_end < e) m_complete(m_rxv);
    endfunction

    function automatic logic [31:0] m_access(input int e, input logic we, input logic [1:0] adr,
                                             input logic [3:0] sel, input logic [31:0] wd,
                                             input logic [7:0] resp);
        logic [31:0] r;
        logic        rxv0;
        r = 32'd0;
        m_settle(e);
        rxv0 = m_rxv;
        if (we) begin
            if (adr == 2'd0 && sel[0] && !m_busy) begin
                m_busy = 1'b1;
                m_end  = e + 16 * (int'(m_div) + 1);
                m_pend = resp;
            end else if (adr == 2'd2) begin
                if (sel[0]) m_cs = wd[0];
                if (sel[1] && !m_busy) m_div = wd[15:8];
            end
        end else begin
            case (adr)
                2'd0: begin r = {24'd0, m_rx}; m_rxv = 1'b0; m_ovr = 1'b0; end
                2'd1: r = {29'd0, m_ovr, m_rxv, m_busy};
                2'd2: r = {16'd0, m_div, 7'd0, m_cs};
                default: r = 32'd0;
            endcase
        end
        if (m_busy && m_end == e) m_complete(rxv0);
        return r;
    endfunction

    typedef struct {
        logic        we;
        logic [1:0]  adr;
        logic [3:0]  sel;
        logic [31:0] wd;
        logic [31:0] exp;
        logic        exp_cs;
    } vec_t;

    initial begin
        vec_t        tv [13];
        logic [31:0] r;
        logic [31:0] exp;
        int          acc, e0, base, g, e, op;
        logic [3:0]  sel;
        logic [31:0] wd;
        logic [7:0]  resp;

        tv[0]  = '{1'b0, 2'd1, 4'h0, 32'h0,        32'h0000_0000, 1'b1};
        tv[1]  = '{1'b0, 2'd2, 4'hF, 32'h0,        32'h0000_0300, 1'b1};
        tv[2]  = '{1'b0, 2'd3, 4'hF, 32'h0,        32'h0000_0000, 1'b1};
        tv[3]  = '{1'b1, 2'd3, 4'hF, 32'hFFFF_FFFF, 32'h0,        1'b1};
        tv[4]  = '{1'b0, 2'd3, 4'hF, 32'h0,        32'h0000_0000, 1'b1};
        tv[5]  = '{1'b1, 2'd2, 4'h2, 32'h0000_0501, 32'h0,        1'b1};
        tv[6]  = '{1'b0, 2'd2, 4'hF, 32'h0,        32'h0000_0500, 1'b1};
        tv[7]  = '{1'b1, 2'd2, 4'h1, 32'h0000_FF01, 32'h0,        1'b0};
        tv[8]  = '{1'b0, 2'd2, 4'h0, 32'h0,        32'h0000_0501, 1'b0};
        tv[9]  = '{1'b1, 2'd0, 4'hE, 32'h0000_00A5, 32'h0,        1'b0};
        tv[10] = '{1'b0, 2'd1, 4'hF, 32'h0,        32'h0000_0000, 1'b0};
        tv[11] = '{1'b1, 2'd2, 4'h3, 32'h0000_0000, 32'h0,        1'b1};
        tv[12] = '{1'b0, 2'd2, 4'hF, 32'h0,        32'h0000_0000, 1'b1};

        // Reset state on the pins.
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_cs",   {31'd0, spi_cs_o},   32'd1);
        chk("rst_sck",  {31'd0, spi_sck_o},  32'd0);
        chk("rst_mosi", {31'd0, spi_mosi_o}, 32'd0);
        chk("rst_ack",  {31'd0, wb_ack_o},   32'd0);
        chk("rst_dat",  wb_dat_o,            32'd0);
        at_neg();
        rst_n_i = 1'b1;

        for (int i = 0; i < 13; i++) begin
            at_neg();
            xact(tv[i].we, tv[i].adr, tv[i].sel, tv[i].wd, r, acc);
            if (!tv[i].we) chk($sformatf("vec%0d_rd", i), r, tv[i].exp);
            chk($sformatf("vec%0d_cs", i), {31'd0, spi_cs_o}, {31'd0, tv[i].exp_cs});
        end

        // div 0, loopback, 0xA5.
        wr(2'd2, 4'h3, 32'h0000_0001, acc);
        chk("t1_cs", {31'd0, spi_cs_o}, 32'd0);
        loopback = 1'b1;
        base = tog_cnt; tog_base = tog_cnt;
        wr(2'd0, 4'h1, 32'h0000_00A5, e0);
        wait_edge(e0 + 16 + 2);
        chk_xfer("t1", base, e0, 0, 8'hA5);
        rd(2'd1, r); chk("t1_status", r, 32'h2);
        rd(2'd0, r); chk("t1_data", r, 32'hA5);
        rd(2'd1, r); chk("t1_status_clr", r, 32'h0);

        // div 3, slave answers 0xC3 to 0x3C.
        loopback = 1'b0; slave_val = 8'hC3;
        wr(2'd2, 4'h3, 32'h0000_0301, acc);
        base = tog_cnt; tog_base = tog_cnt;
        wr(2'd0, 4'h1, 32'h0000_003C, e0);
        rd(2'd1, r); chk("t2_busy", r, 32'h1);
        wait_edge(e0 + 64 + 2);
        chk_xfer("t2", base, e0, 3, 8'h3C);
        rd(2'd0, r); chk("t2_data", r, 32'hC3);

        // Two unread transfers raise overrun; one DATA read clears both flags.
        wr(2'd2, 4'h3, 32'h0000_0001, acc);
        slave_val = 8'h12; tog_base = tog_cnt;
        wr(2'd0, 4'h1, 32'h0000_005A, e0);
        wait_edge(e0 + 18);
        slave_val = 8'h34; tog_base = tog_cnt;
        wr(2'd0, 4'h1, 32'h0000_0077, e0);
        wait_edge(e0 + 18);
        rd(2'd1, r); chk("t3_status", r, 32'h6);
        rd(2'd0, r); chk("t3_data", r, 32'h34);
        rd(2'd1, r); chk("t3_status_clr", r, 32'h0);

        // Writes while busy: DATA and div ignored, cs applied.
        wr(2'd2, 4'h3, 32'h0000_0301, acc);
        loopback = 1'b1;
        base = tog_cnt; tog_base = tog_cnt;
        wr(2'd0, 4'h1, 32'h0000_0022, e0);
        wr(2'd0, 4'h1, 32'h0000_0011, acc);
        wr(2'd2, 4'h3, 32'h0000_0700, acc);
        chk("t4_cs_off", {31'd0, spi_cs_o}, 32'd1);
        rd(2'd2, r); chk("t4_ctrl", r, 32'h0000_0300);
        wait_edge(e0 + 64 + 2);
        chk_xfer("t4", base, e0, 3, 8'h22);
        rd(2'd0, r); chk("t4_data", r, 32'h22);
        repeat (80) @(posedge clk_i);
        at_neg();
        chk("t4_no_second", tog_cnt - base, 32'd16);

        // Reset asserted at half-period 7.
        wr(2'd2, 4'h3, 32'h0000_0001, acc);
        base = tog_cnt; tog_base = tog_cnt;
        wr(2'd0, 4'h1, 32'h0000_0096, e0);
        g = 0;
        while ((tog_cnt - base) < 7 && g < 200) begin
            at_neg();
            g++;
        end
        chk("t5_reach_h7", tog_cnt - base, 32'd7);
        chk("t5_sck_hi", {31'd0, spi_sck_o}, 32'd1);
        rst_n_i = 1'b0;
        #1;
        chk("t5_cs", {31'd0, spi_cs_o}, 32'd1);
        chk("t5_sck", {31'd0, spi_sck_o}, 32'd0);
        repeat (2) at_neg();
        rst_n_i = 1'b1;
        rd(2'd1, r); chk("t5_status", r, 32'h0);
        rd(2'd2, r); chk("t5_ctrl", r, 32'h0000_0300);
        wr(2'd2, 4'h3, 32'h0000_0001, acc);
        base = tog_cnt; tog_base = tog_cnt;
        wr(2'd0, 4'h1, 32'h0000_005C, e0);
        wait_edge(e0 + 18);
        chk_xfer("t5", base, e0, 0, 8'h5C);
        rd(2'd0, r); chk("t5_data", r, 32'h5C);

        // Random traffic against the reference model.
        at_neg();
        rst_n_i = 1'b0;
        loopback = 1'b0;
        repeat (2) at_neg();
        rst_n_i = 1'b1;
        m_reset();
        for (int i = 0; i < 60; i++) begin
            op = $urandom_range(0, 5);
            if (op == 5) begin
                repeat ($urandom_range(0, 40)) @(posedge clk_i);
                continue;
            end
            at_neg();
            e    = edge_n + 1;
            sel  = 4'($urandom_range(0, 15));
            wd   = $urandom;
            resp = 8'($urandom);
            if (op == 0) begin
                m_settle(e);
                if (!m_busy && sel[0]) begin
                    slave_val = resp;
                    tog_base  = tog_cnt;
                end
                exp = m_access(e, 1'b1, 2'd0, sel, wd, resp);
                xact(1'b1, 2'd0, sel, wd, r, acc);
            end else if (op == 3) begin
                wd[15:8] = 8'($urandom_range(0, 2));
                wd[2:1]  = 2'b00;
                exp = m_access(e, 1'b1, 2'd2, sel, wd, resp);
                xact(1'b1, 2'd2, sel, wd, r, acc);
            end else if (op == 4) begin
                exp = m_access(e, wd[31], 2'd3, sel, wd, resp);
                xact(wd[31], 2'd3, sel, wd, r, acc);
                if (!wd[31]) chk("rnd_reg3", r, exp);
            end else begin
                exp = m_access(e, 1'b0, (op == 1) ? 2'd0 : (op == 2) ? 2'd1 : 2'd2, sel, wd, resp);
                xact(1'b0, (op == 1) ? 2'd0 : (op == 2) ? 2'd1 : 2'd2, sel, wd, r, acc);
                chk($sformatf("rnd_rd_op%0d", op), r, exp);
            end
            chk("rnd_cs", {31'd0, spi_cs_o}, {31'd0, ~m_cs});
        end
        repeat (60) @(posedge clk_i);
        at_neg();
        e = edge_n + 1;
        exp = m_access(e, 1'b0, 2'd1, 4'hF, 32'd0, 8'd0);
        xact(1'b0, 2'd1, 4'hF, 32'd0, r, acc);
        chk("rnd_final_status", r, exp);
        at_neg();
        e = edge_n + 1;
        exp = m_access(e, 1'b0, 2'd0, 4'hF, 32'd0, 8'd0);
        xact(1'b0, 2'd0, 4'hF, 32'd0, r, acc);
        chk("rnd_final_data", r, exp);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
